mem_port_arbiter: RTL and testbench

//  Shares one unified memory port between instruction fetch (I) and data load/store (D).

---
 rtl/mem_port_arbiter_pkg.sv | 20 ++
 rtl/mem_port_arbiter_if.sv | 37 +++
 rtl/mem_port_arbiter_stats.sv | 32 +++
 rtl/mem_port_arbiter.sv | 133 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the I/D memory port arbiter.
// Build option: define ARB_STATS_EN to include the grant/wait statistics counters.
package mem_port_arbiter_pkg;

  localparam int WORD           = 64;
  localparam int ARB_STREAK_MAX = 4;

  typedef enum logic [2:0] {
    ARB_IDLE   = 3'd0,
    ARB_BUSY_I = 3'd1,
    ARB_BUSY_D = 3'd2,
    ARB_DONE_I = 3'd3,
    ARB_DONE_D = 3'd4
  } arb_state_e;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, data and memory-side handshake bundle for mem_port_arbiter.
// master = the arbiter; slave = requesters plus memory model.
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW = WORD,
  parameter int DW = WORD
);
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_ack;
  logic [31:0]   i_rdata;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ack;
  logic [DW-1:0] d_rdata;

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;

  modport master (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
    output i_ack, i_rdata, d_ack, d_rdata, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
    input  i_ack, i_rdata, d_ack, d_rdata, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter_stats.sv
// arb_stats: saturating grant / fetch-wait counters for mem_port_arbiter.
// Only instantiated when ARB_STATS_EN is defined.
module arb_stats
  import mem_port_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_grant_i,
  input  logic        i_grant_d,
  input  logic        i_wait_i,
  output logic [31:0] o_i_grants,
  output logic [31:0] o_d_grants,
  output logic [31:0] o_i_wait
);
  logic [31:0] r_i_grants, r_d_grants, r_i_wait;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_i_grants <= '0;
      r_d_grants <= '0;
      r_i_wait   <= '0;
    end else begin
      if (i_grant_i) r_i_grants <= sat_inc32(r_i_grants);
      if (i_grant_d) r_d_grants <= sat_inc32(r_d_grants);
      if (i_wait_i)  r_i_wait   <= sat_inc32(r_i_wait);
    end
  end

  assign o_i_grants = r_i_grants;
  assign o_d_grants = r_d_grants;
  assign o_i_wait   = r_i_wait;
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (I) and load/store (D); D has priority
// but a streak limit lets a pending fetch in. Build option: ARB_STATS_EN.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int STREAK_MAX = ARB_STREAK_MAX,
  parameter int AW         = WORD,
  parameter int DW         = WORD
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_port_arbiter_if.master bus,
  output logic [31:0]        stat_i_grants,
  output logic [31:0]        stat_d_grants,
  output logic [31:0]        stat_i_wait
);
  localparam int SW = $clog2(STREAK_MAX + 1);

  arb_state_e    r_state, w_state_nxt;
  logic [SW-1:0] r_streak;
  logic          w_streak_lt, w_grant_d, w_grant_i, w_mem_done;
  logic          w_i_ack, w_d_ack;

  logic          r_mem_req, r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic [31:0]   r_i_rdata;
  logic [DW-1:0] r_d_rdata;

  assign w_streak_lt = (r_streak < SW'(STREAK_MAX));
  assign w_grant_d   = (r_state == ARB_IDLE) & bus.d_req & (~bus.i_req | w_streak_lt);
  assign w_grant_i   = (r_state == ARB_IDLE) & bus.i_req & ~w_grant_d;
  assign w_mem_done  = ((r_state == ARB_BUSY_I) | (r_state == ARB_BUSY_D)) & bus.mem_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ARB_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ARB_IDLE: begin
        if (w_grant_d)      w_state_nxt = ARB_BUSY_D;
        else if (w_grant_i) w_state_nxt = ARB_BUSY_I;
      end
      ARB_BUSY_I: if (bus.mem_ack) w_state_nxt = ARB_DONE_I;
      ARB_BUSY_D: if (bus.mem_ack) w_state_nxt = ARB_DONE_D;
      default:    w_state_nxt = ARB_IDLE;
    endcase
  end

  always_comb begin
    w_i_ack = 1'b0;
    w_d_ack = 1'b0;
    case (r_state)
      ARB_DONE_I: w_i_ack = 1'b1;
      ARB_DONE_D: w_d_ack = 1'b1;
      default: ;
    endcase
  end

  // Streak counts D grants that bypassed a waiting fetch; any other grant clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_streak <= '0;
    end else if (w_grant_d) begin
      if (!bus.i_req)       r_streak <= '0;
      else if (w_streak_lt) r_streak <= r_streak + SW'(1);
    end else if (w_grant_i) begin
      r_streak <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_i_rdata   <= '0;
      r_d_rdata   <= '0;
    end else begin
      if (w_grant_d) begin
        r_mem_req   <= 1'b1;
        r_mem_we    <= bus.d_we;
        r_mem_addr  <= bus.d_addr;
        r_mem_wdata <= bus.d_wdata;
      end else if (w_grant_i) begin
        r_mem_req   <= 1'b1;
        r_mem_we    <= 1'b0;
        r_mem_addr  <= bus.i_addr;
        r_mem_wdata <= '0;
      end else if (w_mem_done) begin
        r_mem_req   <= 1'b0;
        r_mem_we    <= 1'b0;
      end
      if ((r_state == ARB_BUSY_I) && bus.mem_ack)
        r_i_rdata <= bus.mem_rdata[31:0];
      if ((r_state == ARB_BUSY_D) && bus.mem_ack && !r_mem_we)
        r_d_rdata <= bus.mem_rdata;
    end
  end

  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.i_ack     = w_i_ack;
  assign bus.d_ack     = w_d_ack;
  assign bus.i_rdata   = r_i_rdata;
  assign bus.d_rdata   = r_d_rdata;

`ifdef ARB_STATS_EN
  logic w_i_wait;
  assign w_i_wait = bus.i_req & (r_state != ARB_BUSY_I) & (r_state != ARB_DONE_I);

  arb_stats u_stats (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_grant_i  (w_grant_i),
    .i_grant_d  (w_grant_d),
    .i_wait_i   (w_i_wait),
    .o_i_grants (stat_i_grants),
    .o_d_grants (stat_d_grants),
    .o_i_wait   (stat_i_wait)
  );
`else
  assign stat_i_grants = '0;
  assign stat_d_grants = '0;
  assign stat_i_wait   = '0;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: random requesters and memory latency,
// a cycle-level reference of the arbitration rules, and queued expected read data.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int SMAX = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] stat_i_grants, stat_d_grants, stat_i_wait;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.STREAK_MAX(SMAX)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .stat_i_grants (stat_i_grants),
    .stat_d_grants (stat_d_grants),
    .stat_i_wait   (stat_i_wait)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_str(input string name, input string act, input string exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got '%s' expected '%s'", name, act, exp);
    end
  endtask

  function automatic logic [63:0] hash(input logic [63:0] a);
    return (a * 64'h9E37_79B9_7F4A_7C15) ^ 64'h0123_4567_89AB_CDEF;
  endfunction

  function automatic logic [31:0] ref_imem(input logic [63:0] a);
    logic [63:0] h;
    h = hash(a);
    if (a == 64'h40) return 32'h8B02_0020;
    return h[31:0];
  endfunction

  // ---------------- memory model ----------------
  logic [63:0] mem [logic [63:0]];
  int          mem_wait_mode = -1;
  int          mem_cnt = 0;
  bit          mem_busy = 0;

  initial begin
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        bus.mem_ack = 1'b0;
        mem_busy    = 0;
      end else if (bus.mem_ack) begin
        bus.mem_ack = 1'b0;
        mem_busy    = 0;
      end else if (bus.mem_req) begin
        if (!mem_busy) begin
          mem_busy = 1;
          mem_cnt  = (mem_wait_mode < 0) ? int'($urandom_range(0, 3)) : mem_wait_mode;
        end
        if (mem_cnt == 0) begin
          if (bus.mem_we) begin
            mem[bus.mem_addr] = bus.mem_wdata;
            bus.mem_rdata = {$urandom, $urandom};
          end else begin
            bus.mem_rdata = mem.exists(bus.mem_addr) ? mem[bus.mem_addr] : hash(bus.mem_addr);
          end
          bus.mem_ack = 1'b1;
        end else begin
          mem_cnt--;
        end
      end
    end
  end

  // ---------------- requesters + expected-data scoreboard ----------------
  typedef struct { logic [63:0] addr; logic we; logic [63:0] wdata; } dop_t;

  logic [63:0] i_fix_q [$];
  dop_t        d_fix_q [$];
  int          i_budget = 0, d_budget = 0, i_rate = 100, d_rate = 100;
  logic [31:0] i_exp_q [$];
  logic [63:0] d_exp_q [$];
  logic [63:0] ref_dmem [logic [63:0]];
  logic [63:0] last_load = '0;

  initial begin
    logic        ack;
    logic [63:0] a;
    bus.i_req  = 1'b0;
    bus.i_addr = '0;
    forever begin
      @(negedge clk); ack = bus.i_ack;
      @(posedge clk); #1;
      if (!rst_n) begin
        bus.i_req = 1'b0;
      end else begin
        if (ack) bus.i_req = 1'b0;
        if (!bus.i_req && i_budget > 0 && $urandom_range(1, 100) <= i_rate) begin
          if (i_fix_q.size() > 0) a = i_fix_q.pop_front();
          else                    a = 64'h8000 + 64'($urandom_range(0, 511)) * 8;
          bus.i_addr = a;
          bus.i_req  = 1'b1;
          i_budget--;
          i_exp_q.push_back(ref_imem(a));
        end
      end
    end
  end

  initial begin
    logic        ack;
    dop_t        op;
    logic [63:0] v;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    forever begin
      @(negedge clk); ack = bus.d_ack;
      @(posedge clk); #1;
      if (!rst_n) begin
        bus.d_req = 1'b0;
        last_load = '0;
      end else begin
        if (ack) bus.d_req = 1'b0;
        if (!bus.d_req && d_budget > 0 && $urandom_range(1, 100) <= d_rate) begin
          if (d_fix_q.size() > 0) op = d_fix_q.pop_front();
          else begin
            op.addr  = 64'h1_0000 + 64'($urandom_range(0, 15)) * 8;
            op.we    = 1'($urandom_range(0, 1));
            op.wdata = {$urandom, $urandom};
          end
          bus.d_addr  = op.addr;
          bus.d_we    = op.we;
          bus.d_wdata = op.wdata;
          bus.d_req   = 1'b1;
          d_budget--;
          if (op.we) begin
            ref_dmem[op.addr] = op.wdata;
            d_exp_q.push_back(last_load);
          end else begin
            v = ref_dmem.exists(op.addr) ? ref_dmem[op.addr] : hash(op.addr);
            last_load = v;
            d_exp_q.push_back(v);
          end
        end
      end
    end
  end

  // ---------------- monitor: cycle-level reference of the port ----------------
  // m_free: port idle this cycle; m_inflight: 1=I/2=D owns the port; m_ack_due: ack expected this cycle.
  int          m_free = 1, m_inflight = 0, m_ack_due = 0, m_streak = 0;
  logic [63:0] m_addr, m_wdata;
  logic        m_we;
  int          cnt_ig = 0, cnt_dg = 0, cnt_iw = 0;
  string       glog = "";

  initial begin
    int  nx_ack;
    bit  gd, gi;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_free = 1; m_inflight = 0; m_ack_due = 0; m_streak = 0;
        cnt_ig = 0; cnt_dg = 0; cnt_iw = 0;
        i_exp_q.delete();
        d_exp_q.delete();
      end else begin
        chk("i_ack", 64'(bus.i_ack), 64'(m_ack_due == 1));
        chk("d_ack", 64'(bus.d_ack), 64'(m_ack_due == 2));
        if (m_ack_due == 1) begin
          if (i_exp_q.size() == 0) chk("i_scoreboard_empty", 64'd1, 64'd0);
          else chk("i_rdata", 64'(bus.i_rdata), 64'(i_exp_q.pop_front()));
        end
        if (m_ack_due == 2) begin
          if (d_exp_q.size() == 0) chk("d_scoreboard_empty", 64'd1, 64'd0);
          else chk("d_rdata", bus.d_rdata, d_exp_q.pop_front());
        end
        chk("mem_req", 64'(bus.mem_req), 64'(m_inflight != 0));
        chk("mem_we", 64'(bus.mem_we), 64'((m_inflight == 2) ? m_we : 1'b0));
        if (m_inflight != 0) chk("mem_addr", bus.mem_addr, m_addr);
        if (m_inflight == 2) chk("mem_wdata", bus.mem_wdata, m_wdata);
        if (bus.i_req && !(m_inflight == 1 || m_ack_due == 1)) cnt_iw++;

        nx_ack = 0;
        if (m_free != 0) begin
          gd = bus.d_req && (!bus.i_req || m_streak < SMAX);
          gi = !gd && bus.i_req;
          if (gd) begin
            m_inflight = 2; m_addr = bus.d_addr; m_we = bus.d_we; m_wdata = bus.d_wdata;
            m_streak = bus.i_req ? m_streak + 1 : 0;
            cnt_dg++; glog = {glog, "D"}; m_free = 0;
          end else if (gi) begin
            m_inflight = 1; m_addr = bus.i_addr; m_we = 1'b0;
            m_streak = 0;
            cnt_ig++; glog = {glog, "I"}; m_free = 0;
          end
        end else if (m_inflight != 0) begin
          if (bus.mem_ack) begin
            nx_ack = m_inflight;
            m_inflight = 0;
          end
        end else if (m_ack_due != 0) begin
          m_free = 1;
        end
        m_ack_due = nx_ack;
      end
    end
  end

  task automatic drain(input string name, input int max_cyc);
    bit done;
    done = 0;
    for (int c = 0; c < max_cyc && !done; c++) begin
      @(posedge clk); #3;
      done = (i_budget == 0) && (d_budget == 0) && !bus.i_req && !bus.d_req &&
             (m_free != 0) && (m_inflight == 0) && (m_ack_due == 0);
    end
    if (!done) chk(name, 64'd0, 64'd1);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    bit seen;
    mem[64'h40] = 64'h0000_0000_8B02_0020;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_mem_req",   64'(bus.mem_req),   64'd0);
    chk("rst_mem_we",    64'(bus.mem_we),    64'd0);
    chk("rst_mem_addr",  bus.mem_addr,       64'd0);
    chk("rst_mem_wdata", bus.mem_wdata,      64'd0);
    chk("rst_i_ack",     64'(bus.i_ack),     64'd0);
    chk("rst_d_ack",     64'(bus.d_ack),     64'd0);
    chk("rst_i_rdata",   64'(bus.i_rdata),   64'd0);
    chk("rst_d_rdata",   bus.d_rdata,        64'd0);
    chk("rst_stat_ig",   64'(stat_i_grants), 64'd0);
    chk("rst_stat_dg",   64'(stat_d_grants), 64'd0);
    chk("rst_stat_iw",   64'(stat_i_wait),   64'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // single fetch, zero-wait memory
    mem_wait_mode = 0;
    glog = "";
    i_fix_q.push_back(64'h40);
    i_budget = 1;
    drain("t1_timeout", 50);
    chk_str("t1_grants", glog, "I");
    chk("t1_i_rdata", 64'(bus.i_rdata), 64'h8B02_0020);

    // load then store to the same word, three wait cycles each
    mem_wait_mode = 3;
    d_fix_q.push_back('{addr: 64'h100, we: 1'b0, wdata: 64'h0});
    d_fix_q.push_back('{addr: 64'h100, we: 1'b1, wdata: 64'hDEAD_BEEF});
    d_budget = 2;
    drain("t2_timeout", 80);
    chk("t2_store_landed", mem.exists(64'h100) ? mem[64'h100] : 64'h0, 64'hDEAD_BEEF);
    chk("t2_d_rdata_kept", bus.d_rdata, hash(64'h100));

    // both requesters saturated: streak limit lets I through every fifth grant
    mem_wait_mode = -1;
    glog = "";
    i_budget = 2;
    d_budget = 8;
    drain("t3_timeout", 300);
    chk_str("t3_grant_order", glog, "DDDDIDDDDI");

    // reset while a load is stuck in BUSY_D
    mem_wait_mode = 100;
    d_fix_q.push_back('{addr: 64'h1_0040, we: 1'b0, wdata: 64'h0});
    d_budget = 1;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(posedge clk); #3;
      seen = bus.mem_req;
    end
    chk("t4_mem_req_seen", 64'(seen), 64'd1);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t4_mem_req_async", 64'(bus.mem_req), 64'd0);
    chk("t4_mem_we_async",  64'(bus.mem_we),  64'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t4_no_d_ack", 64'(bus.d_ack), 64'd0);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    mem_wait_mode = -1;
    glog = "";
    i_fix_q.push_back(64'h8100);
    i_budget = 1;
    drain("t4_timeout", 50);
    chk_str("t4_after_reset", glog, "I");

    // randomized traffic
    for (int p = 0; p < 4; p++) begin
      i_rate   = int'($urandom_range(20, 100));
      d_rate   = int'($urandom_range(20, 100));
      i_budget = 25;
      d_budget = 25;
      drain("rand_timeout", 3000);
    end

    repeat (2) @(posedge clk);
    #3;
`ifdef ARB_STATS_EN
    chk("stat_i_grants", 64'(stat_i_grants), 64'(cnt_ig));
    chk("stat_d_grants", 64'(stat_d_grants), 64'(cnt_dg));
    chk("stat_i_wait",   64'(stat_i_wait),   64'(cnt_iw));
`else
    chk("stat_i_grants", 64'(stat_i_grants), 64'd0);
    chk("stat_d_grants", 64'(stat_d_grants), 64'd0);
    chk("stat_i_wait",   64'(stat_i_wait),   64'd0);
`endif
    chk("i_scoreboard_left", 64'(i_exp_q.size()), 64'd0);
    chk("d_scoreboard_left", 64'(d_exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
